// File: rtl/spi_master_arb.sv
// Two-requester SPI master with round-robin arbitration.
// Each accepted command becomes one 24-bit mode-0 frame {id, addr, data}.
// Read data from the last byte is returned to the requester that issued it.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ss high, waiting for a valid request; grants round-robin
// SETUP | ss low, sclk low, first bit presented on mosi
// SHIFT | 24 bits, each CLK_DIV low cycles then CLK_DIV high cycles
// HOLD  | ss low, sclk low, mosi low, after the last high phase
// GAP   | ss high for the slave's post-frame commit window
//
// All outputs are registered from the current state, so they appear
// one cycle after the state that produces them.
module spi_master_arb #(
  parameter int unsigned CLK_DIV    = 8,
  parameter int unsigned GAP_CYCLES = 24,
  parameter logic [7:0]  ID_WRITE   = 8'hFF,
  parameter logic [7:0]  ID_READ    = 8'h00
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic       req0_valid,
  input  logic       req0_write,
  input  logic [7:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_write,
  input  logic [7:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam int unsigned GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [7:0]  HP_LAST  = 8'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);
  localparam logic [4:0]  BIT_LAST = 5'd23;
  localparam logic [4:0]  BIT_RD0  = 5'd16;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t state, state_nx;

  logic [7:0]    hcnt;
  logic          phase;
  logic [4:0]    bit_cnt;
  logic [GW-1:0] gcnt;
  logic [23:0]   frame_sh;
  logic          cmd_write;
  logic          owner;
  logic          last_grant;
  logic [7:0]    cap;
  logic          sample_q;

  logic       any_valid, grant1;
  logic       acc_write;
  logic [7:0] acc_addr, acc_wdata;
  logic       hp_end, bit_end;

  logic ss_d, sclk_d, mosi_d, ready0_d, ready1_d, rsp_valid_d, busy_d;

  // The requester not granted last wins a tie; a lone valid always wins.
  assign any_valid = req0_valid | req1_valid;
  assign grant1    = req1_valid & (~req0_valid | ~last_grant);
  assign acc_write = grant1 ? req1_write : req0_write;
  assign acc_addr  = grant1 ? req1_addr  : req0_addr;
  assign acc_wdata = grant1 ? req1_wdata : req0_wdata;

  assign hp_end  = (hcnt == HP_LAST);
  assign bit_end = (state == SHIFT) && phase && hp_end;

  // State register.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_valid) state_nx = SETUP;
      SETUP:   if (hp_end) state_nx = SHIFT;
      SHIFT:   if (bit_end && (bit_cnt == BIT_LAST)) state_nx = HOLD;
      HOLD:    if (hp_end) state_nx = GAP;
      GAP:     if (gcnt == GAP_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode from the current state; registered below.
  always_comb begin
    ss_d        = 1'b1;
    sclk_d      = 1'b0;
    mosi_d      = 1'b0;
    ready0_d    = 1'b0;
    ready1_d    = 1'b0;
    rsp_valid_d = 1'b0;
    busy_d      = (state != IDLE);
    case (state)
      IDLE: begin
        ready0_d = any_valid & ~grant1;
        ready1_d = grant1;
      end
      SETUP: begin
        ss_d   = 1'b0;
        mosi_d = frame_sh[23];
      end
      SHIFT: begin
        ss_d   = 1'b0;
        sclk_d = phase;
        mosi_d = frame_sh[23];
      end
      HOLD:    ss_d = 1'b0;
      GAP:     rsp_valid_d = (gcnt == '0);
      default: ;
    endcase
  end

  // Registered outputs; response fields only change on a completion.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      ss         <= 1'b1;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_rdata  <= 8'h00;
      busy       <= 1'b0;
    end else begin
      ss         <= ss_d;
      sclk       <= sclk_d;
      mosi       <= mosi_d;
      req0_ready <= ready0_d;
      req1_ready <= ready1_d;
      rsp_valid  <= rsp_valid_d;
      busy       <= busy_d;
      if (rsp_valid_d) begin
        rsp_id    <= owner;
        rsp_rdata <= cmd_write ? 8'h00 : cap;
      end
    end
  end

  // Timers, shift register, command latch and read capture.
  // The miso sample strobe is delayed one cycle so it lands in the last
  // cycle of the registered sclk high phase.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      hcnt       <= 8'h00;
      phase      <= 1'b0;
      bit_cnt    <= 5'd0;
      gcnt       <= '0;
      frame_sh   <= 24'h000000;
      cmd_write  <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cap        <= 8'h00;
      sample_q   <= 1'b0;
    end else begin
      if ((state == SETUP) || (state == SHIFT) || (state == HOLD))
        hcnt <= hp_end ? 8'h00 : hcnt + 8'h01;
      else
        hcnt <= 8'h00;

      if (state != SHIFT)  phase <= 1'b0;
      else if (hp_end)     phase <= ~phase;

      if (state != SHIFT)                        bit_cnt <= 5'd0;
      else if (bit_end && (bit_cnt != BIT_LAST)) bit_cnt <= bit_cnt + 5'd1;

      gcnt <= (state == GAP) ? gcnt + 1'b1 : '0;

      sample_q <= bit_end && (bit_cnt >= BIT_RD0) && !cmd_write;
      if (sample_q) cap <= {cap[6:0], miso};

      if ((state == IDLE) && any_valid) begin
        frame_sh   <= {acc_write ? ID_WRITE : ID_READ, acc_addr,
                       acc_write ? acc_wdata : 8'h00};
        cmd_write  <= acc_write;
        owner      <= grant1;
        last_grant <= grant1;
        cap        <= 8'h00;
      end else if (bit_end) begin
        frame_sh <= {frame_sh[22:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_spi_master_arb.sv
// Bench for spi_master_arb: behavioural SPI slave on the bus, a scoreboard
// of expected completions filled at accept time, and a bus monitor that
// checks frame contents, latency, gap spacing and handshake exclusivity.
module tb_spi_master_arb;

  logic       clock = 1'b0;
  logic       n_reset = 1'b0;
  logic       req0_valid = 1'b0, req0_write = 1'b0;
  logic [7:0] req0_addr = 8'h00, req0_wdata = 8'h00;
  logic       req1_valid = 1'b0, req1_write = 1'b0;
  logic [7:0] req1_addr = 8'h00, req1_wdata = 8'h00;
  logic       req0_ready, req1_ready;
  logic       rsp_valid, rsp_id;
  logic [7:0] rsp_rdata;
  logic       busy, ss, sclk, mosi;
  logic       miso = 1'b0;

  spi_master_arb dut (
    .clock(clock), .n_reset(n_reset),
    .req0_valid(req0_valid), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .busy(busy), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic mapped(input logic [7:0] a);
    return a[7:4] == 4'h1;
  endfunction

  // ---------------- slave model ----------------
  logic [7:0]  s_mem [0:15];
  logic        s_ss_prev = 1'b1, s_sclk_prev = 1'b0;
  int          s_cnt = 0;
  logic [23:0] s_sh = 24'h0;
  logic [7:0]  s_out = 8'h0;

  initial for (int i = 0; i < 16; i++) s_mem[i] = 8'h00;

  // Samples mosi on sclk rise, drives miso after sclk fall, commits a
  // complete write frame when ss returns high.
  always @(negedge clock) begin
    if (ss) begin
      if (!s_ss_prev && s_cnt == 24 && s_sh[23:16] == 8'hFF && mapped(s_sh[15:8]))
        s_mem[s_sh[11:8]] = s_sh[7:0];
      s_cnt = 0;
      miso <= 1'b0;
    end else begin
      if (sclk && !s_sclk_prev) begin
        s_sh  = {s_sh[22:0], mosi};
        s_cnt = s_cnt + 1;
      end
      if (!sclk && s_sclk_prev) begin
        if (s_cnt == 16) begin
          s_out = (s_sh[15:8] == 8'h00 && mapped(s_sh[7:0])) ? s_mem[s_sh[3:0]] : 8'h00;
          miso <= s_out[7];
        end else if (s_cnt > 16 && s_cnt < 24) begin
          s_out = {s_out[6:0], 1'b0};
          miso <= s_out[7];
        end
      end
    end
    s_ss_prev   = ss;
    s_sclk_prev = sclk;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        id;
    logic [7:0]  rdata;
    logic [23:0] frame;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] exp_mem [0:255];
  int         grant_log[$];

  initial for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;

  task automatic issue(input int port, input logic wr, input logic [7:0] addr,
                       input logic [7:0] data);
    exp_t e;
    int   n = 0;
    logic acc = 1'b0;
    if (port == 0) begin
      req0_valid = 1'b1; req0_write = wr; req0_addr = addr; req0_wdata = data;
    end else begin
      req1_valid = 1'b1; req1_write = wr; req1_addr = addr; req1_wdata = data;
    end
    while (!acc && n < 3000) begin
      @(posedge clock);
      #1;
      n++;
      acc = (port == 0) ? req0_ready : req1_ready;
    end
    check_eq("accept_in_time", acc, 1'b1);
    if (acc) begin
      e.id    = port[0];
      e.frame = {wr ? 8'hFF : 8'h00, addr, wr ? data : 8'h00};
      e.rdata = wr ? 8'h00 : (mapped(addr) ? exp_mem[addr] : 8'h00);
      if (wr && mapped(addr)) exp_mem[addr] = data;
      sb_q.push_back(e);
      grant_log.push_back(port);
    end
    if (port == 0) req0_valid = 1'b0;
    else           req1_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clock);
      n++;
    end
    check_eq("drain_in_time", n < 5000, 1'b1);
  endtask

  // ---------------- bus monitor ----------------
  logic        m_ss_prev = 1'b1, m_sclk_prev = 1'b0;
  logic [23:0] m_frame = 24'h0;
  int          m_rises = 0;
  int          ss_high = 0;
  int          rdy_cyc = 0, rsp_cyc = 0;
  logic        rsp_armed = 1'b0;
  int          n_rsp = 0;

  always @(negedge clock) begin
    if (!n_reset) begin
      m_ss_prev   = 1'b1;
      m_sclk_prev = 1'b0;
      m_frame     = 24'h0;
      m_rises     = 0;
      ss_high     = 0;
      rsp_armed   = 1'b0;
    end else begin
      if (req0_ready || req1_ready) begin
        check_eq("one_ready", req0_ready & req1_ready, 1'b0);
        if (rsp_armed) check_eq("ready_after_gap", (cyc - rsp_cyc) >= 25, 1'b1);
        rdy_cyc = cyc;
      end
      if (!ss && sclk && !m_sclk_prev) begin
        m_frame = {m_frame[22:0], mosi};
        m_rises++;
      end
      if (!ss && m_ss_prev) begin
        if (rsp_armed) check_eq("gap_ss_high", ss_high >= 24, 1'b1);
        m_frame = 24'h0;
        m_rises = 0;
      end
      if (ss) ss_high++;
      else    ss_high = 0;
      if (rsp_valid) begin
        exp_t e;
        check_eq("rsp_no_ready", req0_ready | req1_ready, 1'b0);
        check_eq("rsp_expected", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_eq("rsp_id", rsp_id, e.id);
          check_eq("rsp_rdata", rsp_rdata, e.rdata);
          check_eq("frame_bits", m_frame, e.frame);
          check_eq("sclk_rises", m_rises, 24);
          check_eq("latency", cyc - rdy_cyc, 401);
          check_eq("ss_at_rsp", ss, 1'b1);
        end
        rsp_cyc   = cyc;
        rsp_armed = 1'b1;
        n_rsp++;
      end
      m_ss_prev   = ss;
      m_sclk_prev = sclk;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int rsp_snap;

    repeat (3) @(negedge clock);
    check_eq("rst_ss", ss, 1'b1);
    check_eq("rst_sclk", sclk, 1'b0);
    check_eq("rst_mosi", mosi, 1'b0);
    check_eq("rst_ready", {req0_ready, req1_ready}, 2'b00);
    check_eq("rst_rsp", {rsp_valid, rsp_id, rsp_rdata}, 10'h0);
    check_eq("rst_busy", busy, 1'b0);
    @(negedge clock) n_reset = 1'b1;
    repeat (3) @(negedge clock);

    // write then read back through requester 0
    issue(0, 1'b1, 8'h10, 8'hA5);
    wait_drain();
    check_eq("slave_reg10", s_mem[0], 8'hA5);
    issue(0, 1'b0, 8'h10, 8'h00);
    wait_drain();

    // frame format from requester 1
    issue(1, 1'b1, 8'h12, 8'h3C);
    wait_drain();
    check_eq("slave_reg12", s_mem[2], 8'h3C);

    // arbitration: both requesters continuously valid
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) issue(0, 1'b0, 8'h11, 8'h00);
      end
      begin
        for (int i = 0; i < 4; i++) issue(1, 1'b0, 8'h13, 8'h00);
      end
    join
    wait_drain();
    check_eq("arb_count", grant_log.size(), 8);
    for (int i = 0; i < grant_log.size(); i++)
      check_eq("arb_grant", grant_log[i], i % 2);

    // unmapped read after writing a mapped register
    issue(1, 1'b1, 8'h13, 8'h5A);
    wait_drain();
    issue(0, 1'b0, 8'h20, 8'h00);
    wait_drain();
    issue(1, 1'b0, 8'h13, 8'h00);
    wait_drain();

    // back-to-back: write must commit before the following read frame
    issue(0, 1'b1, 8'h15, 8'h66);
    issue(1, 1'b0, 8'h15, 8'h00);
    wait_drain();

    // reset in the middle of a write frame
    issue(0, 1'b1, 8'h14, 8'hEE);
    n = 0;
    while (m_rises < 10 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check_eq("reach_bit10", m_rises >= 10, 1'b1);
    #2 n_reset = 1'b0;
    #1;
    check_eq("midrst_ss", ss, 1'b1);
    check_eq("midrst_sclk", sclk, 1'b0);
    check_eq("midrst_busy", busy, 1'b0);
    sb_q.delete();
    exp_mem[8'h14] = 8'h00;
    rsp_snap = n_rsp;
    repeat (4) @(negedge clock);
    n_reset = 1'b1;
    repeat (500) @(negedge clock);
    check_eq("midrst_no_rsp", n_rsp, rsp_snap);
    check_eq("midrst_no_commit", s_mem[4], 8'h00);

    issue(0, 1'b1, 8'h11, 8'h77);
    wait_drain();
    issue(0, 1'b0, 8'h11, 8'h00);
    wait_drain();
    check_eq("slave_reg11", s_mem[1], 8'h77);
    check_eq("idle_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_arb.md
Name: spi_master_arb

Overview:
- Two-requester SPI master that sequences register write/read frames to the team's SPI slave over a single ss/sclk/mosi/miso bus.
- Round-robin arbitrates between two command ports and serializes each command into one 24-bit frame (slave ID, address, data).
- Returns read data (or write completion) to the issuing requester.
- Sits between on-chip register clients and the board-level SPI slave.

Parameters:
- CLK_DIV, 8, sclk half-period in clock cycles; legal range 4..255.
- GAP_CYCLES, 24, minimum ss-high cycles between frames; minimum 20, which covers the slave's 16-cycle post-frame commit window plus synchronizer delay.
- ID_WRITE, 8'hFF, slave ID byte sent for writes.
- ID_READ, 8'h00, slave ID byte sent for reads.

Ports:
- clock  in  1  system clock
- n_reset  in  1  asynchronous reset, active low
- req0_valid  in  1  requester 0 command valid; held until accepted
- req0_write  in  1  1 = write, 0 = read
- req0_addr  in  8  slave register address
- req0_wdata  in  8  write data; ignored for reads
- req0_ready  out  1  one-cycle accept pulse for requester 0
- req1_valid / req1_write / req1_addr / req1_wdata / req1_ready  same as requester 0, for requester 1
- rsp_valid  out  1  one-cycle completion pulse
- rsp_id  out  1  requester that owns the completing command
- rsp_rdata  out  8  captured read byte; 8'h00 for writes
- busy  out  1  high from accept until the end of GAP
- ss  out  1  slave select, active low, idle high
- sclk  out  1  serial clock, idle low (mode 0)
- mosi  out  1  serial data out
- miso  in  1  serial data in

Behaviour:
- Reset (async, n_reset low), all outputs registered:
  - ss=1, sclk=0, mosi=0, req*_ready=0, rsp_valid=0, rsp_id=0, rsp_rdata=0, busy=0.
  - State returns to IDLE; round-robin pointer is set so requester 0 has priority.
  - A reset mid-frame aborts the frame: no rsp_valid, and the command is lost.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - If any valid is high, grant per round-robin: the requester not granted last wins when both are valid; a lone valid always wins.
  - Pulse reqN_ready for the accept cycle T and latch write, addr and wdata.
  - Build frame = {ID_WRITE or ID_READ, addr, write ? wdata : 8'h00}.
  - Go to SETUP. From T+1: ss=0, busy=1.
- SETUP:
  - CLK_DIV cycles with sclk=0 and mosi = frame[23].
- SHIFT: 24 bits, MSB first. For each bit:
  - CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1.
  - mosi changes only in the cycle sclk goes 1->0, and holds for the whole bit.
  - Reads only: during bits 16..23, miso is sampled in the last cycle of the sclk-high phase and shifted into the capture register MSB first.
  - After bit 23's high phase, sclk=0; go to HOLD.
- HOLD:
  - CLK_DIV cycles with sclk=0, ss=0, mosi=0.
  - Then ss=1, rsp_valid=1 for one cycle with rsp_id and rsp_rdata; go to GAP.
- GAP:
  - ss stays high for GAP_CYCLES cycles; then busy=0 and return to IDLE.
  - New requests are not accepted before IDLE.
- Latency with accept at cycle T: rsp_valid and ss rise at T+1+CLK_DIV*50. Default is T+401.
- Throughput: the next accept is no earlier than rsp_valid cycle + GAP_CYCLES + 1.
- Counters:
  - Half-period counter: 8 bits, wraps to 0 at CLK_DIV-1.
  - Bit counter: 5 bits, 0..23; no other wrap.
- A requester dropping valid before ready is illegal and need not be handled.
- Simultaneous valid from both requesters in IDLE: exactly one ready is asserted per accept.
- rsp_valid never overlaps a ready pulse.

Test Plan:
- Write then read back, with the real slave attached: req0 write addr 8'h10 data 8'hA5, then req0 read addr 8'h10 -> second rsp_valid has rsp_id=0, rsp_rdata=8'hA5; first rsp_rdata=8'h00; slave register 8'h10 = 8'hA5.
- Frame format: req1 write addr 8'h12 data 8'h3C -> mosi bits sampled on the 24 sclk rising edges equal 24'hFF123C; exactly 24 sclk rising edges while ss=0; rsp_valid exactly 401 cycles after req1_ready.
- Arbitration: both valid continuously with 4 reads each (req0 addr 8'h11, req1 addr 8'h13) -> grants alternate 0,1,0,1,... starting with 0; rsp_id sequence matches the grants.
- Unmapped read: read addr 8'h20 after writing 8'h5A to 8'h13 -> rsp_rdata=8'h00.
- Gap spacing: back-to-back requests -> ss high for at least 24 cycles between frames; the second ready comes no earlier than 25 cycles after the first rsp_valid; the slave commits the write before the next frame starts.
- Reset mid-frame: assert n_reset low at bit 10 of a write -> ss=1, sclk=0 immediately; no rsp_valid; after release, a new write to 8'h11 of 8'h77 completes and reads back 8'h77.
